// File: rtl/alu.sv
// alu: registered 8-function ALU with status flags and a one-cycle valid pipeline
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alucont,
    output logic [WIDTH-1:0] aluout,
    output logic             zero,
    output logic             out_valid,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);

    logic [WIDTH-1:0] aluout_q, aluout_d, b_op, res;
    logic [WIDTH:0]   sum;
    logic             zero_q, zero_d, carry_q, carry_d, overflow_q, overflow_d;
    logic             negative_q, negative_d, out_valid_q, out_valid_d;
    logic             sub, arith, add_ovf;

    // Shared adder (SUB/SLT use a + ~b + 1), result select, and hold-when-idle muxing
    always_comb begin
        sub     = alucont[2] & alucont[1];
        b_op    = sub ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
        add_ovf = (a[WIDTH-1] == b_op[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
        arith   = (alucont == 3'b010) | sub;
        case (alucont)
            3'b000:  res = a & b;
            3'b001:  res = a | b;
            3'b011:  res = a ^ b;
            3'b100:  res = a & ~b;
            3'b101:  res = a | ~b;
            3'b111:  res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            default: res = sum[WIDTH-1:0];
        endcase
        aluout_d    = in_valid ? res : aluout_q;
        zero_d      = in_valid ? (res == '0) : zero_q;
        carry_d     = in_valid ? (arith & sum[WIDTH]) : carry_q;
        overflow_d  = in_valid ? (arith & add_ovf) : overflow_q;
        negative_d  = in_valid ? res[WIDTH-1] : negative_q;
        out_valid_d = in_valid;
    end

    // Result and flag registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluout_q    <= '0;
            zero_q      <= 1'b1;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            negative_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            aluout_q    <= aluout_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            negative_q  <= negative_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign aluout    = aluout_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign negative  = negative_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu with a reference model, directed and random stimulus
module tb_alu;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [2:0]   alucont = '0;
    logic [W-1:0] aluout;
    logic         zero, out_valid, carry, overflow, negative;

    typedef struct packed {
        logic [W-1:0] y;
        logic         z;
        logic         c;
        logic         v;
        logic         n;
    } res_t;

    res_t q[$];
    res_t last_exp;
    int   vectors = 0;
    int   miscompares = 0;

    alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .alucont(alucont),
        .aluout(aluout), .zero(zero), .out_valid(out_valid), .carry(carry),
        .overflow(overflow), .negative(negative)
    );

    always #5 clk = ~clk;

    // Reference model from the arithmetic definitions of each opcode
    function automatic res_t model(logic [W-1:0] x, logic [W-1:0] y, logic [2:0] op);
        int ux = int'(x);
        int uy = int'(y);
        int sx = int'($signed(x));
        int sy = int'($signed(y));
        int lim = 2 ** W;
        int r = 0;
        int d = 0;
        bit c = 0;
        bit v = 0;
        res_t e;
        case (op)
            3'd0: r = int'(x & y);
            3'd1: r = int'(x | y);
            3'd3: r = int'(x ^ y);
            3'd4: r = ux & (lim - 1 - uy);
            3'd5: r = (ux | (lim - 1 - uy)) % lim;
            3'd2: begin
                r = (ux + uy) % lim;
                c = (ux + uy) >= lim;
                d = sx + sy;
                v = (d >= lim / 2) || (d < -lim / 2);
            end
            default: begin
                r = (ux - uy + lim) % lim;
                c = ux >= uy;
                d = sx - sy;
                v = (d >= lim / 2) || (d < -lim / 2);
                if (op == 3'd7) r = (sx < sy) ? 1 : 0;
            end
        endcase
        e.y = W'(r);
        e.z = (r == 0);
        e.c = c;
        e.v = v;
        e.n = r >= lim / 2;
        return e;
    endfunction

    function automatic res_t reset_val();
        res_t e;
        e.y = '0; e.z = 1'b1; e.c = 1'b0; e.v = 1'b0; e.n = 1'b0;
        return e;
    endfunction

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic res_t outs();
        res_t e;
        e.y = aluout; e.z = zero; e.c = carry; e.v = overflow; e.n = negative;
        return e;
    endfunction

    // Scoreboard push: every accepted operation queues its expected result
    always @(posedge clk) begin
        if (rst_n && in_valid) q.push_back(model(a, b, alucont));
    end

    // Monitor: pop on out_valid, otherwise outputs must hold the last result
    initial begin
        last_exp = reset_val();
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (q.size() == 0) begin
                    cmp("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    last_exp = q.pop_front();
                    cmp("result", 32'(outs()), 32'(last_exp));
                end
            end else begin
                cmp("hold", 32'(outs()), 32'(last_exp));
            end
        end
    end

    task automatic drive(logic [W-1:0] x, logic [W-1:0] y, logic [2:0] op);
        @(negedge clk);
        in_valid = 1'b1; a = x; b = y; alucont = op;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); alucont = 3'($urandom);
    endtask

    task automatic run1(logic [W-1:0] x, logic [W-1:0] y, logic [2:0] op);
        drive(x, y, op);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        cmp("reset_aluout", 32'(aluout), 32'h00);
        cmp("reset_zero", 32'(zero), 32'd1);
        cmp("reset_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1; a = 8'h12; b = 8'h34; alucont = 3'd2;
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle();
        cmp("op_during_reset_dropped", 32'(out_valid), 32'd0);
        run1(8'hF0, 8'h0F, 3'b000);
        cmp("and_y", 32'(aluout), 32'h00);
        cmp("and_z", 32'(zero), 32'd1);
        cmp("and_ov", 32'(out_valid), 32'd1);
        drive(8'hF0, 8'h0F, 3'b001);
        drive(8'h10, 8'h20, 3'b010);
        cmp("or_y", 32'(aluout), 32'hFF);
        cmp("or_z", 32'(zero), 32'd0);
        idle();
        cmp("add_y", 32'(aluout), 32'h30);
        cmp("b2b_ov", 32'(out_valid), 32'd1);
        run1(8'h20, 8'h10, 3'b110);
        cmp("sub_y", 32'(aluout), 32'h10);
        cmp("sub_cv", 32'({carry, overflow}), 32'b10);
        run1(8'h05, 8'h10, 3'b111);
        cmp("slt_lt", 32'({aluout, zero}), 32'h002);
        run1(8'h10, 8'h05, 3'b111);
        cmp("slt_ge", 32'({aluout, zero}), 32'h001);
        run1(8'h80, 8'h01, 3'b111);
        cmp("slt_signed", 32'(aluout), 32'h01);
        run1(8'h10, 8'hF0, 3'b010);
        cmp("add_wrap", 32'({aluout, zero, carry}), 32'h003);
        run1(8'h7F, 8'h01, 3'b010);
        cmp("add_ovf", 32'({aluout, overflow, negative}), 32'h203);
        idle();
        cmp("hold_ov", 32'(out_valid), 32'd0);
        cmp("hold_y", 32'(aluout), 32'h80);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("async_rst_y", 32'(aluout), 32'h00);
        cmp("async_rst_z", 32'(zero), 32'd1);
        cmp("async_rst_ov", 32'(out_valid), 32'd0);
        last_exp = reset_val();
        #1 rst_n = 1'b1;
        drive(8'h7F, 8'h7F, 3'b010);
        @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        last_exp = reset_val();
        #1 rst_n = 1'b1;
        idle();
        cmp("midop_rst_discard", 32'(out_valid), 32'd0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) != 0)
                drive(W'($urandom), W'($urandom), 3'($urandom));
            else
                idle();
        end
        for (int i = 0; i < 8; i++) begin
            drive(W'($urandom_range(1) ? 8'h80 : 8'h7F), W'($urandom_range(1) ? 8'h80 : 8'h01), 3'($urandom));
        end
        repeat (3) idle();
        cmp("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result bit width (minimum 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  operation request; operands sampled on rising clk when high.
REQ-005 a  input  WIDTH  operand A.
REQ-006 b  input  WIDTH  operand B.
REQ-007 alucont  input  3  operation select (see REQ-011).
REQ-008 aluout  output  WIDTH  registered result.
REQ-009 zero  output  1  registered; high when the registered aluout is all zeros.
REQ-010 out_valid  output  1  registered; high for one cycle per accepted operation.
REQ-010a carry, overflow, negative  output  1 each  registered status flags (see REQ-015..017).

Function
REQ-011 alucont decode: 000 AND (a&b); 001 OR (a|b); 010 ADD (a+b); 011 XOR (a^b); 100 AND-NOT (a&~b); 101 OR-NOT (a|~b); 110 SUB (a-b); 111 SLT.
REQ-012 ADD/SUB results are modulo 2^WIDTH; overflow bits beyond WIDTH are discarded from aluout.
REQ-013 SLT: signed two's-complement compare; aluout = 1 (zero-extended to WIDTH) if a < b, else 0; overflow-corrected (a<b = sign(a-b) XOR overflow(a-b)).
REQ-014 SUB and SLT compute a + ~b + 1 through the same adder as ADD.
REQ-015 carry = adder carry-out for ADD, SUB, SLT (SUB: carry=1 means no borrow); 0 for logic ops.
REQ-016 overflow = signed overflow of the adder for ADD, SUB, SLT; 0 for logic ops.
REQ-017 negative = MSB of the result written to aluout.
REQ-018 zero = 1 exactly when the result written to aluout equals 0, for every opcode.
REQ-019 Latency: operation accepted at rising edge N (in_valid=1) appears on aluout/flags after edge N, with out_valid=1 during cycle N+1.
REQ-020 Throughput: one operation per cycle; back-to-back in_valid produces back-to-back results, out_valid stays high.
REQ-021 in_valid=0 at an edge: aluout and all flags hold previous values; out_valid goes 0.
REQ-022 No backpressure; results are not stalled or buffered beyond one register stage.
REQ-023 Inputs are don't-care when in_valid=0; X on them shall not propagate to outputs.

Reset
REQ-024 rst_n low asynchronously forces aluout=0, zero=1, carry=0, overflow=0, negative=0, out_valid=0, independent of clk.
REQ-025 While rst_n low, in_valid is ignored; an operation presented at the edge where rst_n is low is discarded.
REQ-026 Reset asserted mid-operation discards the pending result; first valid result follows the first accepting edge after rst_n deasserts.
REQ-027 rst_n deassertion is synchronised by the system; the block needs no internal reset synchroniser.

Verification
REQ-028 AND: a=F0, b=0F, alucont=000, in_valid=1 -> next cycle aluout=00, zero=1, out_valid=1.
REQ-029 OR then ADD back-to-back: (F0,0F,001) then (10,20,010) -> aluout=FF zero=0, then aluout=30 zero=0, out_valid high both cycles.
REQ-030 SUB: a=20, b=10, alucont=110 -> aluout=10, zero=0, carry=1, overflow=0.
REQ-031 SLT: (05,10,111) -> aluout=01, zero=0; (10,05,111) -> aluout=00, zero=1; signed case (80,01,111) -> aluout=01.
REQ-032 ADD wrap: a=10, b=F0, alucont=010 -> aluout=00, zero=1, carry=1; ADD a=7F,b=01 -> aluout=80, overflow=1, negative=1.
REQ-033 Hold/reset: drop in_valid -> outputs hold, out_valid=0; pulse rst_n low between edges -> outputs immediately aluout=00, zero=1, out_valid=0.
